id_ex_stage: RTL and testbench

//  ID/EX pipeline register and operand-select stage directly upstream of the ALU.

---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/ex_forward_mux.sv | 36 +++
 rtl/id_ex_stage.sv | 128 ++++++++++++
 tb/tb_id_ex_stage.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU package: widths, ALU opcodes,
// comparator encodings and the ID/EX bundle.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [3:0] BUBBLE_OP = ALU_AND;

  localparam logic [1:0] CMP_OFF = 2'b00;
  localparam logic [1:0] CMP_NE  = 2'b01;
  localparam logic [1:0] CMP_EQ  = 2'b11;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RA_W-1:0] rs1_addr;
    logic [RA_W-1:0] rs2_addr;
    logic [RA_W-1:0] rd_addr;
    logic [3:0]      alu_control;
    logic [1:0]      equal_comp;
    logic            alu_src_a;
    logic            alu_src_b;
    logic            mem_read;
    logic            reg_write;
  } id_ex_t;

endpackage

// File: rtl/ex_forward_mux.sv
// Priority forwarding mux for one EX operand:
// EX/MEM over MEM/WB over register file, x0 never forwarded.
module ex_forward_mux
  import cpu_pkg::*;
(
  input  logic [RA_W-1:0] rs,
  input  logic [XLEN-1:0] rf_data,
  input  logic            exmem_reg_write,
  input  logic [RA_W-1:0] exmem_rd_addr,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_reg_write,
  input  logic [RA_W-1:0] memwb_rd_addr,
  input  logic [XLEN-1:0] memwb_result,
  output logic [XLEN-1:0] data
);

  logic hit_exmem;
  logic hit_memwb;

  assign hit_exmem = exmem_reg_write
                   & (exmem_rd_addr != '0)
                   & (exmem_rd_addr == rs);
  assign hit_memwb = memwb_reg_write
                   & (memwb_rd_addr != '0)
                   & (memwb_rd_addr == rs);

  // youngest producer wins
  always_comb begin
    data = rf_data;
    if (hit_exmem)
      data = exmem_result;
    else if (hit_memwb)
      data = memwb_result;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX register with load-use stall, flush
// and operand forwarding into the ALU.
module id_ex_stage
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rs1_addr,
  input  logic [RA_W-1:0] id_rs2_addr,
  input  logic [RA_W-1:0] id_rd_addr,
  input  logic [3:0]      id_alu_control,
  input  logic [1:0]      id_equalComp,
  input  logic            id_alu_src_a,
  input  logic            id_alu_src_b,
  input  logic            id_mem_read,
  input  logic            id_reg_write,
  input  logic            ex_flush,
  input  logic            exmem_reg_write,
  input  logic [RA_W-1:0] exmem_rd_addr,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_reg_write,
  input  logic [RA_W-1:0] memwb_rd_addr,
  input  logic [XLEN-1:0] memwb_result,
  output logic            stall_id,
  output logic [XLEN-1:0] ScrA,
  output logic [XLEN-1:0] ScrB,
  output logic [3:0]      alu_control,
  output logic [1:0]      equalComp,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_store_data,
  output logic [RA_W-1:0] ex_rd_addr,
  output logic            ex_reg_write,
  output logic            ex_mem_read
);

  id_ex_t          id_in;
  id_ex_t          ex_q;
  logic            rd_hit;
  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;

  // pack the decode slot into the stage bundle
  always_comb begin
    id_in             = '0;
    id_in.valid       = id_valid;
    id_in.pc          = id_pc;
    id_in.rs1_data    = id_rs1_data;
    id_in.rs2_data    = id_rs2_data;
    id_in.imm         = id_imm;
    id_in.rs1_addr    = id_rs1_addr;
    id_in.rs2_addr    = id_rs2_addr;
    id_in.rd_addr     = id_rd_addr;
    id_in.alu_control = id_alu_control;
    id_in.equal_comp  = id_equalComp;
    id_in.alu_src_a   = id_alu_src_a;
    id_in.alu_src_b   = id_alu_src_b;
    id_in.mem_read    = id_mem_read;
    id_in.reg_write   = id_reg_write;
  end

  assign rd_hit = (ex_q.rd_addr == id_rs1_addr)
                | (ex_q.rd_addr == id_rs2_addr);

  assign stall_id = id_valid
                  & ex_q.valid
                  & ex_q.mem_read
                  & (ex_q.rd_addr != '0)
                  & rd_hit;

  // reset, then bubble on flush/stall/empty slot, else load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q             <= '0;
      ex_q.alu_control <= BUBBLE_OP;
      ex_q.equal_comp  <= CMP_OFF;
    end else if (ex_flush || stall_id || !id_valid) begin
      ex_q.valid       <= 1'b0;
      ex_q.reg_write   <= 1'b0;
      ex_q.mem_read    <= 1'b0;
      ex_q.alu_control <= BUBBLE_OP;
      ex_q.equal_comp  <= CMP_OFF;
    end else begin
      ex_q <= id_in;
    end
  end

  ex_forward_mux u_fwd_a (
    .rs              (ex_q.rs1_addr),
    .rf_data         (ex_q.rs1_data),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd_addr   (exmem_rd_addr),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd_addr   (memwb_rd_addr),
    .memwb_result    (memwb_result),
    .data            (fwd_a)
  );

  ex_forward_mux u_fwd_b (
    .rs              (ex_q.rs2_addr),
    .rf_data         (ex_q.rs2_data),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd_addr   (exmem_rd_addr),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd_addr   (memwb_rd_addr),
    .memwb_result    (memwb_result),
    .data            (fwd_b)
  );

  assign ScrA          = ex_q.alu_src_a ? ex_q.pc  : fwd_a;
  assign ScrB          = ex_q.alu_src_b ? ex_q.imm : fwd_b;
  assign ex_store_data = fwd_b;
  assign alu_control   = ex_q.alu_control;
  assign equalComp     = ex_q.equal_comp;
  assign ex_valid      = ex_q.valid;
  assign ex_pc         = ex_q.pc;
  assign ex_rd_addr    = ex_q.rd_addr;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios then
// random traffic against a behavioural model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [3:0]  id_alu_control;
  logic [1:0]  id_equalComp;
  logic        id_alu_src_a, id_alu_src_b;
  logic        id_mem_read, id_reg_write;
  logic        ex_flush;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd_addr;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd_addr;
  logic [31:0] memwb_result;
  logic        stall_id;
  logic [31:0] ScrA, ScrB, ex_pc, ex_store_data;
  logic [3:0]  alu_control;
  logic [1:0]  equalComp;
  logic        ex_valid, ex_reg_write, ex_mem_read;
  logic [4:0]  ex_rd_addr;

  int total = 0;
  int bad   = 0;

  // model of what EX currently holds
  logic        m_valid, m_sa, m_sb, m_mr, m_rw;
  logic [31:0] m_pc, m_a, m_b, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [3:0]  m_op;
  logic [1:0]  m_cmp;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rd_addr(id_rd_addr), .id_alu_control(id_alu_control),
    .id_equalComp(id_equalComp), .id_alu_src_a(id_alu_src_a),
    .id_alu_src_b(id_alu_src_b), .id_mem_read(id_mem_read),
    .id_reg_write(id_reg_write), .ex_flush(ex_flush),
    .exmem_reg_write(exmem_reg_write),
    .exmem_rd_addr(exmem_rd_addr), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write),
    .memwb_rd_addr(memwb_rd_addr), .memwb_result(memwb_result),
    .stall_id(stall_id), .ScrA(ScrA), .ScrB(ScrB),
    .alu_control(alu_control), .equalComp(equalComp),
    .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] rs,
                                      input logic [31:0] rf);
    if (exmem_reg_write && exmem_rd_addr != 0 && exmem_rd_addr == rs)
      return exmem_result;
    if (memwb_reg_write && memwb_rd_addr != 0 && memwb_rd_addr == rs)
      return memwb_result;
    return rf;
  endfunction

  function automatic logic exp_stall();
    return id_valid && m_valid && m_mr && m_rd != 0
        && (m_rd == id_rs1_addr || m_rd == id_rs2_addr);
  endfunction

  task automatic model_update();
    logic st;
    st = exp_stall();
    if (!rst_n) begin
      {m_valid, m_sa, m_sb, m_mr, m_rw} = '0;
      {m_pc, m_a, m_b, m_imm} = '0;
      {m_rs1, m_rs2, m_rd} = '0;
      m_op = 4'b0000;
      m_cmp = 2'b00;
    end else if (ex_flush || st || !id_valid) begin
      m_valid = 0; m_rw = 0; m_mr = 0;
      m_op = 4'b0000; m_cmp = 2'b00;
    end else begin
      m_valid = 1;          m_pc = id_pc;
      m_a = id_rs1_data;    m_b = id_rs2_data;
      m_imm = id_imm;       m_rs1 = id_rs1_addr;
      m_rs2 = id_rs2_addr;  m_rd = id_rd_addr;
      m_op = id_alu_control; m_cmp = id_equalComp;
      m_sa = id_alu_src_a;  m_sb = id_alu_src_b;
      m_mr = id_mem_read;   m_rw = id_reg_write;
    end
  endtask

  task automatic check_all();
    logic [31:0] fa, fb;
    fa = fwd(m_rs1, m_a);
    fb = fwd(m_rs2, m_b);
    chk("stall_id", {31'd0, stall_id}, {31'd0, exp_stall()});
    chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
    chk("alu_control", {28'd0, alu_control}, {28'd0, m_op});
    chk("equalComp", {30'd0, equalComp}, {30'd0, m_cmp});
    chk("ex_rd_addr", {27'd0, ex_rd_addr}, {27'd0, m_rd});
    chk("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, m_rw});
    chk("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, m_mr});
    chk("ex_pc", ex_pc, m_pc);
    if (m_valid) begin
      chk("ScrA", ScrA, m_sa ? m_pc : fa);
      chk("ScrB", ScrB, m_sb ? m_imm : fb);
      chk("store_data", ex_store_data, fb);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc,
                        input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] rd,
                        input logic [3:0] op, input logic [1:0] cmp,
                        input logic sa, input logic sb,
                        input logic mr, input logic rw);
    id_valid = v; id_pc = pc; id_rs1_data = d1; id_rs2_data = d2;
    id_imm = imm; id_rs1_addr = r1; id_rs2_addr = r2;
    id_rd_addr = rd; id_alu_control = op; id_equalComp = cmp;
    id_alu_src_a = sa; id_alu_src_b = sb;
    id_mem_read = mr; id_reg_write = rw;
  endtask

  task automatic no_fwd();
    exmem_reg_write = 0; exmem_rd_addr = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd_addr = 0; memwb_result = 0;
  endtask

  initial begin
    rst_n = 0; ex_flush = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    no_fwd();
    @(negedge clk);
    tick(); tick();

    // 1: reset state, idle slot
    rst_n = 1;
    #1;
    check_all();
    chk("t1_ScrA", ScrA, 32'd0);
    chk("t1_ScrB", ScrB, 32'd0);
    chk("t1_alu", {28'd0, alu_control}, 32'd0);
    chk("t1_valid", {31'd0, ex_valid}, 32'd0);
    tick();
    #1; check_all();

    // 2: ADD x3 = x1 + x2
    set_id(1, 32'h40, 5, 7, 0, 1, 2, 3, 4'b0010, 0, 0, 0, 0, 1);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1; check_all();
    chk("t2_ScrA", ScrA, 32'd5);
    chk("t2_ScrB", ScrB, 32'd7);
    chk("t2_alu", {28'd0, alu_control}, 32'h2);
    chk("t2_rd", {27'd0, ex_rd_addr}, 32'd3);
    tick();

    // 3: EX/MEM beats MEM/WB; x0 never forwarded
    set_id(1, 32'h44, 32'h11, 32'h22, 0, 1, 2, 3, 4'b0010, 0, 0, 0, 0, 1);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    exmem_reg_write = 1; exmem_rd_addr = 1; exmem_result = 32'hAA;
    memwb_reg_write = 1; memwb_rd_addr = 1; memwb_result = 32'hBB;
    #1; check_all();
    chk("t3_exmem_wins", ScrA, 32'hAA);
    exmem_rd_addr = 0; memwb_rd_addr = 0;
    #1; check_all();
    chk("t3_x0_guard", ScrA, 32'h11);
    no_fwd();
    tick();

    // 4: load-use on rs2 -> one stall, then MEM/WB forward
    set_id(1, 32'h48, 0, 0, 8, 0, 0, 4, 4'b0010, 0, 0, 1, 1, 1);
    tick();
    set_id(1, 32'h4C, 32'h1, 32'h2, 0, 0, 4, 5, 4'b0010, 0, 0, 0, 0, 1);
    #1; check_all();
    chk("t4_stall", {31'd0, stall_id}, 32'd1);
    tick();
    #1; check_all();
    chk("t4_bubble", {31'd0, ex_valid}, 32'd0);
    chk("t4_stall_off", {31'd0, stall_id}, 32'd0);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    memwb_reg_write = 1; memwb_rd_addr = 4; memwb_result = 32'h1234;
    #1; check_all();
    chk("t4_ScrB", ScrB, 32'h1234);
    no_fwd();
    tick();

    // 5: flush together with load-use
    set_id(1, 32'h50, 0, 0, 0, 0, 0, 6, 4'b0010, 0, 0, 1, 1, 1);
    tick();
    set_id(1, 32'h54, 3, 4, 0, 6, 0, 7, 4'b0110, 2'b11, 0, 0, 0, 1);
    ex_flush = 1;
    #1; check_all();
    chk("t5_stall", {31'd0, stall_id}, 32'd1);
    tick();
    ex_flush = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1; check_all();
    chk("t5_rw", {31'd0, ex_reg_write}, 32'd0);
    chk("t5_cmp", {30'd0, equalComp}, 32'd0);
    tick();

    // 6: PC/imm sources, store data still forwarded
    set_id(1, 32'h100, 32'h5, 32'h77, 32'hFFFFFFFC, 1, 2, 0,
           4'b0010, 0, 1, 1, 0, 0);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    exmem_reg_write = 1; exmem_rd_addr = 2; exmem_result = 32'h99;
    #1; check_all();
    chk("t6_ScrA", ScrA, 32'h100);
    chk("t6_ScrB", ScrB, 32'hFFFFFFFC);
    chk("t6_store", ex_store_data, 32'h99);
    no_fwd();
    tick();

    // random traffic with small register space for frequent hazards
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      ex_flush = ($urandom_range(0, 7) == 0);
      set_id($urandom_range(0, 3) != 0, $urandom, $urandom,
             $urandom, $urandom,
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 4'($urandom_range(0, 9)),
             2'($urandom), 1'($urandom), 1'($urandom),
             $urandom_range(0, 2) == 0, 1'($urandom));
      exmem_reg_write = 1'($urandom);
      exmem_rd_addr = 5'($urandom_range(0, 3));
      exmem_result = $urandom;
      memwb_reg_write = 1'($urandom);
      memwb_rd_addr = 5'($urandom_range(0, 3));
      memwb_result = $urandom;
      #1;
      if (rst_n) check_all();
      tick();
    end
    rst_n = 1;
    #1; check_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
